// File: rtl/ascon_pkg.sv
// Shared constants and the controller state enumeration for the Ascon-Hash sponge.
package ascon_pkg;

  localparam int RATE_W   = 64;
  localparam int STATE_W  = 320;
  localparam int DIGEST_W = 256;
  localparam int ROUNDS_A = 12;

  // Ascon-Hash v1.2 initial value for x0; x1..x4 start at zero.
  localparam logic [RATE_W-1:0] ASCON_HASH_IV = 64'h00400c0000000100;

  // Padding block used when the final message block was completely full.
  localparam logic [RATE_W-1:0] PAD_FULL = 64'h8000000000000000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ABSORB,
    PERM_ABS,
    PAD_EXTRA,
    PERM_SQZ,
    SQZ_TAKE,
    DONE
  } sponge_state_t;

endpackage

// File: rtl/ascon_pad.sv
// Combinational padding of the final rate block: keep the first msg_bytes bytes,
// append 0x80, fill with zeros. A count of 8 or more passes the block through.
module ascon_pad
  import ascon_pkg::*;
(
  input  logic [RATE_W-1:0] msg_data,
  input  logic [3:0]        msg_bytes,
  output logic [RATE_W-1:0] padded
);

  // Per-byte select between message byte, padding marker and zero.
  always_comb begin
    padded = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < msg_bytes) begin
        padded[63-8*i -: 8] = msg_data[63-8*i -: 8];
      end else if (4'(i) == msg_bytes) begin
        padded[63-8*i -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sponge_ctrl.sv
// Ascon-Hash sponge controller: owns the 320-bit state, absorbs 64-bit message
// blocks, sequences an external permutation core and squeezes a 256-bit digest.
module sponge_ctrl
  import ascon_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                msg_valid,
  input  logic [RATE_W-1:0]   msg_data,
  input  logic                msg_last,
  input  logic [3:0]          msg_bytes,
  output logic                msg_ready,
  output logic                perm_start,
  output logic [4:0]          perm_rounds,
  output logic [STATE_W-1:0]  perm_state,
  input  logic [STATE_W-1:0]  perm_out,
  input  logic                perm_done,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic                busy
);

  sponge_state_t       st;
  logic [STATE_W-1:0]  s;
  logic [1:0]          sqz_cnt;
  logic [RATE_W-1:0]   pad_blk;
  logic [RATE_W-1:0]   x0;
  logic                perm_phase;
  logic                perm_fin;
  logic                accept;
  logic                last_full;

  ascon_pad u_pad (
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .padded    (pad_blk)
  );

  assign x0          = s[STATE_W-1 -: RATE_W];
  assign perm_state  = s;
  assign perm_rounds = 5'(ROUNDS_A);
  assign perm_phase  = st inside {INIT, PERM_ABS, PAD_EXTRA, PERM_SQZ};
  // A done pulse only counts while this block has a request outstanding.
  assign perm_fin    = perm_phase && perm_start && perm_done;
  assign accept      = msg_valid && msg_ready;
  assign last_full   = msg_bytes >= 4'd8;

  // Main sponge FSM with registered handshake outputs and state/digest storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      s            <= '0;
      sqz_cnt      <= '0;
      digest       <= '0;
      msg_ready    <= 1'b0;
      perm_start   <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          // The offered block is left on the bus; it is consumed in ABSORB.
          if (msg_valid) begin
            s       <= {ASCON_HASH_IV, {(STATE_W-RATE_W){1'b0}}};
            sqz_cnt <= '0;
            busy    <= 1'b1;
            st      <= INIT;
          end
        end
        INIT, PERM_ABS: begin
          if (perm_fin) begin
            s          <= perm_out;
            perm_start <= 1'b0;
            msg_ready  <= 1'b1;
            st         <= ABSORB;
          end else begin
            perm_start <= 1'b1;
          end
        end
        ABSORB: begin
          if (accept) begin
            msg_ready <= 1'b0;
            if (!msg_last) begin
              s[STATE_W-1 -: RATE_W] <= x0 ^ msg_data;
              st                     <= PERM_ABS;
            end else if (last_full) begin
              s[STATE_W-1 -: RATE_W] <= x0 ^ msg_data;
              st                     <= PAD_EXTRA;
            end else begin
              s[STATE_W-1 -: RATE_W] <= x0 ^ pad_blk;
              sqz_cnt                <= '0;
              st                     <= PERM_SQZ;
            end
          end
        end
        PAD_EXTRA: begin
          // The padding-only block is folded in as the permuted state is captured.
          if (perm_fin) begin
            s          <= {perm_out[STATE_W-1 -: RATE_W] ^ PAD_FULL,
                           perm_out[STATE_W-RATE_W-1:0]};
            sqz_cnt    <= '0;
            perm_start <= 1'b0;
            st         <= PERM_SQZ;
          end else begin
            perm_start <= 1'b1;
          end
        end
        PERM_SQZ: begin
          if (perm_fin) begin
            s          <= perm_out;
            perm_start <= 1'b0;
            st         <= SQZ_TAKE;
          end else begin
            perm_start <= 1'b1;
          end
        end
        SQZ_TAKE: begin
          digest[DIGEST_W-1-RATE_W*int'(sqz_cnt) -: RATE_W] <= x0;
          sqz_cnt <= sqz_cnt + 2'd1;
          if (sqz_cnt == 2'd3) begin
            digest_valid <= 1'b1;
            st           <= DONE;
          end else begin
            st <= PERM_SQZ;
          end
        end
        DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            st           <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sponge_ctrl.sv
// Bench for sponge_ctrl: pairs the controller with a one-round-per-cycle Ascon
// permutation core and a byte-oriented software Ascon-Hash reference.
module tb_sponge_ctrl;
  import ascon_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_valid = 1'b0;
  logic [63:0]  msg_data = '0;
  logic         msg_last = 1'b0;
  logic [3:0]   msg_bytes = '0;
  logic         msg_ready;
  logic         perm_start;
  logic [4:0]   perm_rounds;
  logic [319:0] perm_state;
  logic [319:0] perm_out;
  logic         perm_done;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] msg_mem [0:7];

  localparam logic [255:0] EMPTY_DIGEST =
    256'h7346bc14f036e87ae03d0997913088f5f68411434b3cf8b54fa796a80d251f91;

  sponge_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .msg_last     (msg_last),
    .msg_bytes    (msg_bytes),
    .msg_ready    (msg_ready),
    .perm_start   (perm_start),
    .perm_rounds  (perm_rounds),
    .perm_state   (perm_state),
    .perm_out     (perm_out),
    .perm_done    (perm_done),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ---------------- Ascon permutation reference ----------------
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] st, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    x0 = st[319:256]; x1 = st[255:192]; x2 = st[191:128]; x3 = st[127:64]; x4 = st[63:0];
    c  = 8'((((15 - r) << 4) | r));
    x2 = x2 ^ {56'h0, c};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = x0 ^ (~x1 & x2);
    t1 = x1 ^ (~x2 & x3);
    t2 = x2 ^ (~x3 & x4);
    t3 = x3 ^ (~x4 & x0);
    t4 = x4 ^ (~x0 & x1);
    t1 = t1 ^ t0; t0 = t0 ^ t4; t3 = t3 ^ t2; t2 = ~t2;
    x0 = t0 ^ ror(t0, 19) ^ ror(t0, 28);
    x1 = t1 ^ ror(t1, 61) ^ ror(t1, 39);
    x2 = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
    x3 = t3 ^ ror(t3, 10) ^ ror(t3, 17);
    x4 = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] perm12(input logic [319:0] st);
    for (int r = 0; r < 12; r++) st = ascon_round(st, r);
    return st;
  endfunction

  // Software Ascon-Hash over msg_mem: nblk blocks, lastb bytes used in the final one.
  function automatic logic [255:0] model_hash(input int nblk, input int lastb);
    logic [7:0]   mb [0:95];
    logic [319:0] st;
    logic [63:0]  blk;
    logic [255:0] h;
    int           len;
    int           lb;
    lb  = (lastb > 8) ? 8 : lastb;
    len = 0;
    for (int i = 0; i < nblk; i++) begin
      int nb;
      nb = (i == nblk - 1) ? lb : 8;
      for (int j = 0; j < nb; j++) begin
        mb[len] = msg_mem[i][63-8*j -: 8];
        len++;
      end
    end
    mb[len] = 8'h80;
    len++;
    while ((len % 8) != 0) begin
      mb[len] = 8'h00;
      len++;
    end
    st = {64'h00400c0000000100, 256'h0};
    st = perm12(st);
    for (int c = 0; c < len / 8; c++) begin
      for (int j = 0; j < 8; j++) blk[63-8*j -: 8] = mb[8*c+j];
      st[319:256] = st[319:256] ^ blk;
      st = perm12(st);
    end
    h[255:192] = st[319:256];
    for (int k = 1; k < 4; k++) begin
      st = perm12(st);
      h[255-64*k -: 64] = st[319:256];
    end
    return h;
  endfunction

  // Cycle-accurate permutation core: latches on a start rising edge, one round per cycle.
  logic [319:0] pm_s;
  logic [3:0]   pm_rnd;
  logic         pm_run;
  logic         pm_start_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pm_run     <= 1'b0;
      pm_rnd     <= '0;
      pm_start_q <= 1'b0;
      perm_done  <= 1'b0;
    end else begin
      pm_start_q <= perm_start;
      perm_done  <= 1'b0;
      if (!pm_run && perm_start && !pm_start_q) begin
        pm_s   <= perm_state;
        pm_rnd <= '0;
        pm_run <= 1'b1;
      end else if (pm_run) begin
        pm_s   <= ascon_round(pm_s, int'(pm_rnd) + 12 - int'(perm_rounds));
        pm_rnd <= pm_rnd + 4'd1;
        if (pm_rnd == 4'(perm_rounds - 5'd1)) begin
          pm_run    <= 1'b0;
          perm_done <= 1'b1;
          perm_out  <= ascon_round(pm_s, int'(pm_rnd) + 12 - int'(perm_rounds));
        end
      end
    end
  end

  // Event monitors: permutation requests, ready violations, PAD_EXTRA visits, accepts.
  logic ps_q = 1'b0;
  int   perm_edges = 0;
  int   ready_viol = 0;
  int   pad_visits = 0;
  int   accepts = 0;
  always @(posedge clk) begin
    ps_q <= perm_start;
    if (perm_start && !ps_q) perm_edges <= perm_edges + 1;
    if (msg_ready && (perm_start || dut.st != ABSORB)) ready_viol <= ready_viol + 1;
    if (dut.st == PAD_EXTRA) pad_visits <= pad_visits + 1;
    if (msg_valid && msg_ready) accepts <= accepts + 1;
  end

  // ---------------- stimulus tasks ----------------
  task automatic run_hash(input int nblk, input int lastb, input bit rnd, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < nblk && ok; i++) begin
      int cyc;
      bit acc;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        msg_data  = msg_valid ? msg_mem[i] : ~msg_mem[i];
        msg_last  = (i == nblk - 1);
        msg_bytes = (i == nblk - 1) ? 4'(lastb) : 4'd0;
        if (msg_valid && msg_ready) acc = 1'b1;
      end
      if (!acc) ok = 1'b0;
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    if (ok) begin
      int cyc2;
      cyc2 = 0;
      while (!digest_valid && cyc2 < 3000) begin
        @(negedge clk);
        cyc2++;
      end
      if (!digest_valid) ok = 1'b0;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({msg_ready, perm_start, digest_valid, busy} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {msg_ready, perm_start, digest_valid, busy});
    end
    n_checks++;
    if (perm_rounds !== 5'd12) begin
      n_errors++;
      $display("FAIL reset_rounds: got %0d required 12", perm_rounds);
    end
    n_checks++;
    if (digest !== 256'h0 || perm_state !== 320'h0) begin
      n_errors++;
      $display("FAIL reset_data: digest %h state %h required zero", digest, perm_state);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.st !== IDLE || busy !== 1'b0 || perm_rounds !== 5'd12) begin
      n_errors++;
      $display("FAIL post_reset: state %0d busy %b rounds %0d required IDLE 0 12", dut.st, busy, perm_rounds);
    end
  endtask

  task automatic test_empty();
    bit ok;
    int e0;
    msg_mem[0] = 64'ha5a55a5a0f0ff0f0;
    e0 = perm_edges;
    run_hash(1, 0, 1'b0, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL empty_timeout: got no digest_valid required digest_valid=1");
    end
    n_checks++;
    if (digest !== EMPTY_DIGEST) begin
      n_errors++;
      $display("FAIL empty_digest: got %h required %h", digest, EMPTY_DIGEST);
    end
    n_checks++;
    if (perm_edges - e0 !== 5) begin
      n_errors++;
      $display("FAIL empty_perms: got %0d required 5", perm_edges - e0);
    end
    consume();
    n_checks++;
    if ({digest_valid, busy} !== 2'b00 || dut.st !== IDLE) begin
      n_errors++;
      $display("FAIL empty_release: valid,busy %b state %0d required 00 IDLE", {digest_valid, busy}, dut.st);
    end
  endtask

  task automatic test_single_full();
    bit ok;
    int e0, p0;
    logic [255:0] exp;
    msg_mem[0] = 64'h0001020304050607;
    exp = model_hash(1, 8);
    e0 = perm_edges;
    p0 = pad_visits;
    run_hash(1, 8, 1'b0, ok);
    n_checks++;
    if (!ok || digest !== exp) begin
      n_errors++;
      $display("FAIL full_digest: got %h required %h", digest, exp);
    end
    n_checks++;
    if (perm_edges - e0 !== 6) begin
      n_errors++;
      $display("FAIL full_perms: got %0d required 6", perm_edges - e0);
    end
    n_checks++;
    if (pad_visits - p0 == 0) begin
      n_errors++;
      $display("FAIL full_pad_extra: got 0 PAD_EXTRA cycles required at least 1");
    end
    consume();
  endtask

  task automatic test_three_blocks();
    bit ok;
    int e0, v0;
    logic [255:0] exp;
    msg_mem[0] = 64'h0011223344556677;
    msg_mem[1] = 64'h8899aabbccddeeff;
    msg_mem[2] = 64'hdeadbeefcafef00d;
    exp = model_hash(3, 3);
    e0 = perm_edges;
    v0 = ready_viol;
    run_hash(3, 3, 1'b0, ok);
    n_checks++;
    if (!ok || digest !== exp) begin
      n_errors++;
      $display("FAIL three_digest: got %h required %h", digest, exp);
    end
    n_checks++;
    if (perm_edges - e0 !== 7) begin
      n_errors++;
      $display("FAIL three_perms: got %0d required 7", perm_edges - e0);
    end
    n_checks++;
    if (ready_viol - v0 !== 0) begin
      n_errors++;
      $display("FAIL three_ready: got %0d cycles of msg_ready outside ABSORB required 0", ready_viol - v0);
    end
    consume();
  endtask

  task automatic test_done_stall();
    bit ok;
    logic [255:0] exp;
    msg_mem[0] = 64'h1122334455667788;
    msg_mem[1] = 64'h99aabbccddeeff00;
    exp = model_hash(2, 7);
    run_hash(2, 7, 1'b0, ok);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (!ok || digest_valid !== 1'b1 || digest !== exp) begin
        n_errors++;
        $display("FAIL stall_hold: cycle %0d valid %b digest %h required 1 %h", k, digest_valid, digest, exp);
      end
      @(negedge clk);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    n_checks++;
    if ({digest_valid, busy} !== 2'b00 || dut.st !== IDLE) begin
      n_errors++;
      $display("FAIL stall_release: valid,busy %b state %0d required 00 IDLE", {digest_valid, busy}, dut.st);
    end
  endtask

  task automatic test_reset_mid_sqz();
    bit ok;
    int cyc, e0;
    msg_mem[0] = 64'h0;
    cyc = 0;
    @(negedge clk);
    msg_valid = 1'b1;
    msg_last  = 1'b1;
    msg_bytes = 4'd0;
    // Advance to the second squeeze permutation so the digest register holds a word.
    while (!(dut.st == PERM_SQZ && perm_start && dut.sqz_cnt == 2'd1) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (dut.st != IDLE && dut.st != INIT && dut.st != ABSORB) msg_valid = 1'b0;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    n_checks++;
    if (cyc >= 3000) begin
      n_errors++;
      $display("FAIL midsqz_reach: got no PERM_SQZ with perm_start required one");
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({msg_ready, perm_start, digest_valid, busy} !== 4'b0000 || dut.st !== IDLE) begin
      n_errors++;
      $display("FAIL midsqz_ctrl: got %b state %0d required 0000 IDLE",
               {msg_ready, perm_start, digest_valid, busy}, dut.st);
    end
    n_checks++;
    if (digest !== 256'h0 || perm_state !== 320'h0 || perm_rounds !== 5'd12) begin
      n_errors++;
      $display("FAIL midsqz_data: digest %h state %h rounds %0d required 0 0 12", digest, perm_state, perm_rounds);
    end
    rst = 1'b0;
    @(negedge clk);
    e0 = perm_edges;
    run_hash(1, 0, 1'b0, ok);
    n_checks++;
    if (!ok || digest !== EMPTY_DIGEST || perm_edges - e0 !== 5) begin
      n_errors++;
      $display("FAIL midsqz_rehash: got %h perms %0d required %h perms 5", digest, perm_edges - e0, EMPTY_DIGEST);
    end
    consume();
  endtask

  task automatic test_random_valid();
    bit ok;
    int e0, a0;
    logic [255:0] exp;
    msg_mem[0] = 64'h0102030405060708;
    msg_mem[1] = 64'hf0e0d0c0b0a09080;
    msg_mem[2] = 64'h5555aaaa5555aaaa;
    msg_mem[3] = 64'h0123456789abcdef;
    msg_mem[4] = 64'hfedcba9876543210;
    exp = model_hash(5, 5);
    e0 = perm_edges;
    a0 = accepts;
    run_hash(5, 5, 1'b1, ok);
    n_checks++;
    if (!ok || digest !== exp) begin
      n_errors++;
      $display("FAIL random_digest: got %h required %h", digest, exp);
    end
    n_checks++;
    if (accepts - a0 !== 5) begin
      n_errors++;
      $display("FAIL random_accepts: got %0d required 5", accepts - a0);
    end
    n_checks++;
    if (perm_edges - e0 !== 9) begin
      n_errors++;
      $display("FAIL random_perms: got %0d required 9", perm_edges - e0);
    end
    consume();
  endtask

  task automatic test_bytes_clamp();
    bit ok;
    int e0;
    logic [255:0] exp;
    msg_mem[0] = 64'h0706050403020100;
    exp = model_hash(1, 8);
    e0 = perm_edges;
    run_hash(1, 15, 1'b0, ok);
    n_checks++;
    if (!ok || digest !== exp || perm_edges - e0 !== 6) begin
      n_errors++;
      $display("FAIL clamp_digest: got %h perms %0d required %h perms 6", digest, perm_edges - e0, exp);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single_full();
    test_three_blocks();
    test_done_stall();
    test_reset_mid_sqz();
    test_random_valid();
    test_bytes_clamp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
